// File: rtl/cfmac_pkg.sv
// Shared constants and arithmetic helpers for the complex fixed-point MAC pipeline.
package cfmac_pkg;

  localparam int REAL = 0;
  localparam int IMAG = 1;

  function automatic int acc_bits(input int in_bits, input int guard_bits);
    return 2*in_bits + 1 + guard_bits;
  endfunction

  // Round half toward +inf, then drop frac_bits fractional bits.
  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v,
                                                       input int frac_bits);
    return (v + (64'sd1 <<< (frac_bits-1))) >>> frac_bits;
  endfunction

  function automatic logic out_of_range(input logic signed [63:0] r, input int out_bits);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (out_bits-1);
    return (r >= lim) || (r < -lim);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] r,
                                                  input int out_bits);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (out_bits-1);
    if (r >= lim) return lim - 64'sd1;
    if (r < -lim) return -lim;
    return r;
  endfunction

endpackage

// File: rtl/cfmac_round_sat.sv
// Combinational round + range limit for one accumulator component.
// CFMAC_SATURATE_EN selects clamping; otherwise the low OUT_BITS bits wrap.
module cfmac_round_sat
  import cfmac_pkg::*;
#(
  parameter int ACC_BITS  = 41,
  parameter int FRAC_BITS = 16,
  parameter int OUT_BITS  = 18
) (
  input  logic signed [ACC_BITS-1:0] acc,
  output logic        [OUT_BITS-1:0] z,
  output logic                       ovf
);

  logic signed [63:0] wide, rnd, lmt;

  always_comb begin
    wide = 64'(acc);
    rnd  = round_half_up(wide, FRAC_BITS);
    ovf  = out_of_range(rnd, OUT_BITS);
`ifdef CFMAC_SATURATE_EN
    lmt  = saturate(rnd, OUT_BITS);
`else
    lmt  = rnd;
`endif
    z    = OUT_BITS'(lmt);
  end

endmodule

// File: rtl/complex_fix_mac_pipe.sv
// Four-stage pipelined complex fixed-point MAC with conj mode, rounding and overflow flag.
// Build option CFMAC_SATURATE_EN: clamp out-of-range results instead of wrapping.
module complex_fix_mac_pipe
  import cfmac_pkg::*;
#(
  parameter int IN_BITS    = 18,
  parameter int FRAC_BITS  = 16,
  parameter int OUT_BITS   = 18,
  parameter int GUARD_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic                     in_conj,
  input  logic [1:0][IN_BITS-1:0]  in_x,
  input  logic [1:0][IN_BITS-1:0]  in_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0][OUT_BITS-1:0] out_z,
  output logic                     out_ovf
);

  localparam int ACC_BITS = acc_bits(IN_BITS, GUARD_BITS);
  localparam int PW       = 2*IN_BITS;
  localparam int SW       = PW + 1;
  localparam int STAGES   = 4;

  logic [STAGES:1]          vld_pipe;
  logic                     stall, accept;
  logic [1:0][IN_BITS-1:0]  x1, y1;
  logic                     conj1, last1, conj2, last2;
  logic signed [PW-1:0]     ac, bd, ad, bc;
  logic signed [SW-1:0]     sum [2];
  logic signed [ACC_BITS-1:0] acc [2];
  logic signed [ACC_BITS-1:0] nxt [2];
  logic signed [ACC_BITS-1:0] res [2];
  logic                     acc_empty;
  logic [OUT_BITS-1:0]      rnd_z [2];
  logic                     rnd_ovf [2];

  assign out_valid = vld_pipe[STAGES];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;

  // Conj flips the sign of every term involving the imaginary part of y.
  always_comb begin
    sum[REAL] = conj2 ? SW'(ac) + SW'(bd) : SW'(ac) - SW'(bd);
    sum[IMAG] = conj2 ? SW'(bc) - SW'(ad) : SW'(ad) + SW'(bc);
    for (int c = 0; c < 2; c++)
      nxt[c] = acc_empty ? ACC_BITS'(sum[c]) : acc[c] + ACC_BITS'(sum[c]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      x1        <= '0;
      y1        <= '0;
      conj1     <= 1'b0;
      last1     <= 1'b0;
      conj2     <= 1'b0;
      last2     <= 1'b0;
      ac        <= '0;
      bd        <= '0;
      ad        <= '0;
      bc        <= '0;
      acc_empty <= 1'b1;
      out_z     <= '0;
      out_ovf   <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        acc[c] <= '0;
        res[c] <= '0;
      end
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[3], vld_pipe[2] && last2, vld_pipe[1], accept};
      if (accept) begin
        x1    <= in_x;
        y1    <= in_y;
        conj1 <= in_conj;
        last1 <= in_last;
      end
      if (vld_pipe[1]) begin
        ac    <= PW'($signed(x1[REAL])) * PW'($signed(y1[REAL]));
        bd    <= PW'($signed(x1[IMAG])) * PW'($signed(y1[IMAG]));
        ad    <= PW'($signed(x1[REAL])) * PW'($signed(y1[IMAG]));
        bc    <= PW'($signed(x1[IMAG])) * PW'($signed(y1[REAL]));
        conj2 <= conj1;
        last2 <= last1;
      end
      // A last beat hands its sum to S4 and leaves the accumulator empty so
      // the next beat reloads rather than adds.
      if (vld_pipe[2]) begin
        if (last2) begin
          for (int c = 0; c < 2; c++) res[c] <= nxt[c];
          acc_empty <= 1'b1;
        end else begin
          for (int c = 0; c < 2; c++) acc[c] <= nxt[c];
          acc_empty <= 1'b0;
        end
      end
      if (vld_pipe[3]) begin
        out_z[REAL] <= rnd_z[REAL];
        out_z[IMAG] <= rnd_z[IMAG];
        out_ovf     <= rnd_ovf[REAL] | rnd_ovf[IMAG];
      end
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_rs
    cfmac_round_sat #(
      .ACC_BITS (ACC_BITS),
      .FRAC_BITS(FRAC_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_rs (
      .acc(res[c]),
      .z  (rnd_z[c]),
      .ovf(rnd_ovf[c])
    );
  end

endmodule

// File: tb/tb_complex_fix_mac_pipe.sv
// Scoreboard bench for complex_fix_mac_pipe at IN=8, FRAC=6, OUT=8, GUARD=4 (1.0 = 64).
module tb_complex_fix_mac_pipe;

  localparam int IB = 8, FB = 6, OB = 8, GB = 4;

  typedef struct {
    logic [OB-1:0] re;
    logic [OB-1:0] im;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, in_conj = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_ovf;
  logic [1:0][IB-1:0] in_x = '0, in_y = '0;
  logic [1:0][OB-1:0] out_z;

  int     checks = 0, fails = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  longint m_re = 0, m_im = 0;
  bit     m_empty = 1'b1;

  always #5 clk = ~clk;

  complex_fix_mac_pipe #(.IN_BITS(IB), .FRAC_BITS(FB), .OUT_BITS(OB), .GUARD_BITS(GB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_conj(in_conj), .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_ovf(out_ovf)
  );

  function automatic exp_t expect_of(input longint re, input longint im);
    exp_t   e;
    longint v[2], r[2], hi, lo;
    v[0] = re; v[1] = im;
    hi = (64'sd1 <<< (OB-1)) - 1;
    lo = -(64'sd1 <<< (OB-1));
    e.ovf = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r[k] = (v[k] + (64'sd1 <<< (FB-1))) >>> FB;
      if (r[k] > hi || r[k] < lo) begin
        e.ovf = 1'b1;
`ifdef CFMAC_SATURATE_EN
        r[k] = (r[k] > hi) ? hi : lo;
`endif
      end
    end
    e.re = r[0][OB-1:0];
    e.im = r[1][OB-1:0];
    return e;
  endfunction

  // Scoreboard: every output transfer pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got z=(%0d,%0d) ovf=%0b with no result pending",
                 $signed(out_z[0]), $signed(out_z[1]), out_ovf);
      end else begin
        mon_e = sb.pop_front();
        if (out_z[0] !== mon_e.re || out_z[1] !== mon_e.im || out_ovf !== mon_e.ovf) begin
          fails++;
          $display("FAIL result: got z=(%0d,%0d) ovf=%0b, expected z=(%0d,%0d) ovf=%0b",
                   $signed(out_z[0]), $signed(out_z[1]), out_ovf,
                   $signed(mon_e.re), $signed(mon_e.im), mon_e.ovf);
        end
      end
    end
  end

  // Drive one beat, wait for acceptance, update the reference accumulator.
  task automatic beat(input int a, input int b, input int c, input int d,
                      input bit cj, input bit lst);
    longint pr, pi, la, lb, lc, ld;
    bit ok = 1'b0;
    in_x[0] = IB'(a); in_x[1] = IB'(b);
    in_y[0] = IB'(c); in_y[1] = IB'(d);
    in_conj = cj; in_last = lst; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_conj = 1'b0;
    if (!ok) begin
      checks++; fails++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end else begin
      la = a; lb = b; lc = c; ld = d;
      pr = cj ? la*lc + lb*ld : la*lc - lb*ld;
      pi = cj ? lb*lc - la*ld : la*ld + lb*lc;
      if (m_empty) begin m_re = pr; m_im = pi; end
      else begin m_re += pr; m_im += pi; end
      m_empty = 1'b0;
      if (lst) begin
        sb.push_back(expect_of(m_re, m_im));
        m_empty = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d results still pending, required 0", name, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (out_z !== '0) begin fails++; $display("FAIL reset_out_z: got %h, required 0", out_z); end
    checks++;
    if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_out_ovf: got %b, required 0", out_ovf); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_latency();
    int lat = 0;
    beat(64, 0, 32, 32, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat != 4) begin fails++; $display("FAIL latency: got %0d cycles, required 4", lat); end
    wait_drain("single");
  endtask

  task automatic test_conj();
    beat(0, 64, 0, 64, 1'b0, 1'b1);
    beat(0, 64, 0, 64, 1'b1, 1'b1);
    wait_drain("conj");
  endtask

  task automatic test_accumulate();
    for (int k = 0; k < 3; k++) beat(32, 0, 64, 0, 1'b0, k == 2);
    beat(1, 0, 32, 0, 1'b0, 1'b1);
    wait_drain("accumulate");
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) beat(127, 0, 127, 0, 1'b0, k == 3);
    beat(-128, -128, -128, -128, 1'b1, 1'b1);
    wait_drain("overflow");
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++)
        beat(int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100,
             int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100,
             1'($urandom_range(1)), k == n-1);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_backpressure();
    logic [1:0][OB-1:0] held;
    logic               held_ovf;
    bit seen = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int s = 0; s < 6; s++)
          beat(int'($urandom_range(120)) - 60, int'($urandom_range(120)) - 60,
               int'($urandom_range(120)) - 60, int'($urandom_range(120)) - 60,
               1'($urandom_range(1)), 1'b1);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (out_valid === 1'b1) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin fails++; $display("FAIL stall_out_valid: got 0, required 1 within 40 cycles"); end
        held = out_z; held_ovf = out_ovf;
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_z !== held || out_ovf !== held_ovf) begin
            fails++;
            $display("FAIL stall_hold: got in_ready=%b out_valid=%b z=%h ovf=%b, required 0 1 %h %b",
                     in_ready, out_valid, out_z, out_ovf, held, held_ovf);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("backpressure");
  endtask

  task automatic test_reset_mid_sum();
    beat(50, 0, 40, 0, 1'b0, 1'b0);
    beat(50, 0, 40, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    beat(64, 0, 64, 0, 1'b0, 1'b1);
    wait_drain("reset_mid_sum");
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_conj();
    test_accumulate();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_sum();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
